// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data-SRAM responder.
// Optional feature macro: DATA_SRAM_WRITE_FIRST_EN (see data_sram_responder.sv).
package data_sram_responder_pkg;

    localparam int DSRAM_DATA_W = 32;
    localparam int DSRAM_BE_W   = 4;

    localparam logic [31:0] DSRAM_BASE_ADDR_DEFAULT = 32'h1c00_0000;

    // Byte-lane merge: lanes with be[i]=1 come from new_word, others from old_word.
    function automatic logic [DSRAM_DATA_W-1:0] dsram_byte_merge(
        input logic [DSRAM_DATA_W-1:0] old_word,
        input logic [DSRAM_DATA_W-1:0] new_word,
        input logic [DSRAM_BE_W-1:0]   be
    );
        logic [DSRAM_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < DSRAM_BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_sat_counter32.sv
// 32-bit saturating event counter with synchronous reset and a preload port.
// The count sticks at 32'hFFFF_FFFF instead of wrapping.
module sat_counter32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] count
);

    // Reset wins, then preload, then a saturating increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 32'd0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the data-SRAM port driven by the MEM stage.
// One access per cycle, rdata returned with a fixed 1-cycle latency,
// byte-lane writes, sticky out-of-window capture and access counters.
//
// Interface semantics: there is no valid/ready pair. data_sram_en is a
// qualifier only; every cycle with en=1 (and reset=0) is accepted at that
// rising edge, and the responder never stalls the requester.
//
// Optional feature macro: DATA_SRAM_WRITE_FIRST_EN
//   defined   : a read+write in the same cycle returns the merged new word
//   undefined : read-first, the old word is returned
// Memory contents after the edge are identical in both modes.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR  = DSRAM_BASE_ADDR_DEFAULT,
    parameter              INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_sram_en,
    input  logic [DSRAM_BE_W-1:0]   data_sram_we,
    input  logic [31:0]             data_sram_addr,
    input  logic [DSRAM_DATA_W-1:0] data_sram_wdata,
    output logic [DSRAM_DATA_W-1:0] data_sram_rdata,
    output logic                    oob_err,
    output logic [31:0]             oob_addr,
    output logic [31:0]             rd_cnt,
    output logic [31:0]             wr_cnt
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int TAG_LSB = DEPTH_LOG2 + 2;

    // Contents start undefined; a simulation harness may preload mem
    // hierarchically from INIT_FILE.
    localparam unused_init_file = INIT_FILE;

    logic [DSRAM_DATA_W-1:0] mem [DEPTH];

    logic                    in_win;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    hit;
    logic                    wr_hit;
    logic                    rd_only_hit;
    logic                    oob_hit;
    logic [DSRAM_DATA_W-1:0] old_word;
    logic [DSRAM_DATA_W-1:0] merged_word;
    logic [DSRAM_DATA_W-1:0] read_word;
    logic                    unused_addr_lsbs;

    assign unused_addr_lsbs = ^data_sram_addr[1:0];

    // Window decode and access classification.
    always_comb begin
        in_win      = (data_sram_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
        idx         = data_sram_addr[TAG_LSB-1:2];
        hit         = data_sram_en && in_win;
        wr_hit      = hit && (data_sram_we != '0);
        rd_only_hit = hit && (data_sram_we == '0);
        oob_hit     = data_sram_en && !in_win;
        old_word    = mem[idx];
        merged_word = dsram_byte_merge(old_word, data_sram_wdata, data_sram_we);
`ifdef DATA_SRAM_WRITE_FIRST_EN
        read_word   = merged_word;
`else
        read_word   = old_word;
`endif
    end

    // Storage array: byte-lane write, never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_hit) begin
            mem[idx] <= merged_word;
        end
    end

    // Read data register: holds on idle cycles, zero for out-of-window.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sram_rdata <= '0;
        end else if (hit) begin
            data_sram_rdata <= read_word;
        end else if (oob_hit) begin
            data_sram_rdata <= '0;
        end
    end

    // Sticky capture of the first out-of-window access address.
    always_ff @(posedge clk) begin
        if (reset) begin
            oob_err  <= 1'b0;
            oob_addr <= 32'd0;
        end else if (oob_hit && !oob_err) begin
            oob_err  <= 1'b1;
            oob_addr <= data_sram_addr;
        end
    end

    sat_counter32 u_rd_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (rd_only_hit),
        .load     (1'b0),
        .load_val (32'd0),
        .count    (rd_cnt)
    );

    sat_counter32 u_wr_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (wr_hit),
        .load     (1'b0),
        .load_val (32'd0),
        .count    (wr_cnt)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder plus a standalone saturation
// check of sat_counter32.
module tb_data_sram_responder;

`ifdef DATA_SRAM_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        oob_err;
    logic [31:0] oob_addr;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    logic        sat_reset;
    logic        sat_inc;
    logic        sat_load;
    logic [31:0] sat_load_val;
    logic [31:0] sat_count;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .oob_err         (oob_err),
        .oob_addr        (oob_addr),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
    );

    sat_counter32 u_sat (
        .clk      (clk),
        .reset    (sat_reset),
        .inc      (sat_inc),
        .load     (sat_load),
        .load_val (sat_load_val),
        .count    (sat_count)
    );

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic e, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = rst;
        en    = e;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // row: en, we, addr, wdata, check rdata?, expected rdata after the edge
        vecs[0]  = '{1'b1, 4'hF, 32'h1c00_0010, 32'h1122_3344, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 4'h0, 32'h1c00_0010, 32'h0,         1'b1, 32'h1122_3344};
        vecs[2]  = '{1'b1, 4'h5, 32'h1c00_0010, 32'hAABB_CCDD, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'h0, 32'h1c00_0010, 32'h0,         1'b1, 32'h11BB_33DD};
        vecs[4]  = '{1'b1, 4'hF, 32'h1c00_0020, 32'h1234_5678, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 4'hF, 32'h1c00_0020, 32'hFFFF_0000, 1'b1,
                     WF ? 32'hFFFF_0000 : 32'h1234_5678};
        vecs[6]  = '{1'b1, 4'h0, 32'h1c00_0020, 32'h0,         1'b1, 32'hFFFF_0000};
        vecs[7]  = '{1'b0, 4'hF, 32'h1c00_0020, 32'h5555_5555, 1'b1, 32'hFFFF_0000};
        vecs[8]  = '{1'b1, 4'hF, 32'h1c00_fffc, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 4'h0, 32'h1c00_fffc, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b1, 4'h0, 32'h1c00_0013, 32'h0,         1'b1, 32'h11BB_33DD};
        vecs[11] = '{1'b1, 4'h0, 32'h1c00_0020, 32'h0,         1'b1, 32'hFFFF_0000};

        reset = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
        sat_reset = 1'b1; sat_inc = 1'b0; sat_load = 1'b0; sat_load_val = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_rdata", rdata, 32'h0);
        check32("reset_oob_err", {31'h0, oob_err}, 32'h0);
        check32("reset_oob_addr", oob_addr, 32'h0);
        check32("reset_rd_cnt", rd_cnt, 32'h0);
        check32("reset_wr_cnt", wr_cnt, 32'h0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk) check32($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end
        // writes: rows 0,2,4,5,8; reads (we=0): rows 1,3,6,9,10,11
        check32("table_wr_cnt", wr_cnt, 32'd5);
        check32("table_rd_cnt", rd_cnt, 32'd6);
        check32("table_oob_err", {31'h0, oob_err}, 32'h0);

        // ---- out-of-window sequence ----
        drive(1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
        check32("oob1_rdata", rdata, 32'h0);
        check32("oob1_err", {31'h0, oob_err}, 32'h1);
        check32("oob1_addr", oob_addr, 32'h0000_0040);
        drive(1'b0, 1'b1, 4'h0, 32'h2000_0000, 32'h0);
        drive(1'b0, 1'b1, 4'hF, 32'h2000_0010, 32'h5555_5555);
        check32("oob2_rdata", rdata, 32'h0);
        check32("oob2_addr_kept", oob_addr, 32'h0000_0040);
        check32("oob2_err", {31'h0, oob_err}, 32'h1);
        check32("oob_wr_cnt", wr_cnt, 32'd5);
        check32("oob_rd_cnt", rd_cnt, 32'd6);
        drive(1'b0, 1'b1, 4'h0, 32'h1c01_0000, 32'h0);
        check32("oob_past_end_rdata", rdata, 32'h0);
        drive(1'b0, 1'b1, 4'h0, 32'h1c00_0010, 32'h0);
        check32("oob_mem_untouched", rdata, 32'h11BB_33DD);
        check32("oob_then_rd_cnt", rd_cnt, 32'd7);

        // ---- hold on idle, then reset mid-stream ----
        drive(1'b0, 1'b1, 4'hF, 32'h1c00_0030, 32'hCAFE_BABE);
        drive(1'b0, 1'b1, 4'h0, 32'h1c00_0030, 32'h0);
        check32("cafe_rdata", rdata, 32'hCAFE_BABE);
        for (int i = 0; i < 5; i++) begin
            idle();
            check32($sformatf("hold%0d_rdata", i), rdata, 32'hCAFE_BABE);
        end
        check32("pre_reset_wr_cnt", wr_cnt, 32'd6);
        check32("pre_reset_rd_cnt", rd_cnt, 32'd8);
        // write presented during reset must be ignored
        drive(1'b1, 1'b1, 4'hF, 32'h1c00_0030, 32'h0000_0000);
        check32("mid_reset_rdata", rdata, 32'h0);
        check32("mid_reset_oob_err", {31'h0, oob_err}, 32'h0);
        check32("mid_reset_oob_addr", oob_addr, 32'h0);
        check32("mid_reset_rd_cnt", rd_cnt, 32'h0);
        check32("mid_reset_wr_cnt", wr_cnt, 32'h0);
        idle();
        check32("post_reset_idle_rdata", rdata, 32'h0);
        check32("post_reset_wr_cnt", wr_cnt, 32'h0);
        drive(1'b0, 1'b1, 4'h0, 32'h1c00_0030, 32'h0);
        check32("post_reset_mem", rdata, 32'hCAFE_BABE);
        check32("post_reset_rd_cnt", rd_cnt, 32'd1);

        // ---- counter saturation ----
        @(negedge clk);
        sat_reset = 1'b0; sat_inc = 1'b1;
        @(posedge clk); #1;
        check32("sat_first_inc", sat_count, 32'd1);
        @(negedge clk);
        sat_inc = 1'b0; sat_load = 1'b1; sat_load_val = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        check32("sat_load", sat_count, 32'hFFFF_FFFE);
        @(negedge clk);
        sat_load = 1'b0; sat_inc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check32($sformatf("sat_inc%0d", i), sat_count, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        sat_inc = 1'b0; sat_reset = 1'b1;
        @(posedge clk); #1;
        check32("sat_reset", sat_count, 32'h0);

        // ---- report ----
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
